// File: rtl/mem_bank_pkg.sv
// Shared constants, grant classification and helpers for the IF-sample bank controller.
package mem_bank_pkg;

  localparam int MEM_BANK_WORD_LENGTH = 24;
  localparam int MEM_BANK_ADDR_WIDTH  = 13;
  localparam int MEM_BANK_RD_LATENCY  = 4;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WR   = 2'd1,
    GRANT_RD   = 2'd2
  } grant_kind_e;

  // ceil(log2(n)), clamped to 1 so a single-reader build still has a legal pointer width.
  function automatic int reader_id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bank_ctrl_rr_arbiter.sv
// Combinational round-robin picker: lowest requester at or above ptr wins, else lowest overall.
module rr_arbiter
  import mem_bank_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = reader_id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] next_ptr
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] sel;

  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign hi_mask[gi] = (gi >= int'(ptr));
  end

  assign req_hi = req & hi_mask;
  assign sel    = (|req_hi) ? req_hi : req;
  // Isolate the lowest set bit of the chosen request vector.
  assign gnt    = sel & (~sel + N'(1));

  always_comb begin
    next_ptr = ptr;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

endmodule

// File: rtl/mem_bank_ctrl.sv
// Single-port sample-bank access controller: write priority with a burst guard,
// round-robin reads, and a tag pipeline steering returned words to their reader.
module mem_bank_ctrl
  import mem_bank_pkg::*;
#(
  parameter int WORD_LENGTH  = MEM_BANK_WORD_LENGTH,
  parameter int ADDR_WIDTH   = MEM_BANK_ADDR_WIDTH,
  parameter int NUM_READERS  = 4,
  parameter int MAX_WR_BURST = 8
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              wr_req,
  input  logic [ADDR_WIDTH-1:0]             wr_addr,
  input  logic [WORD_LENGTH-1:0]            wr_data,
  output logic                              wr_ack,
  input  logic [NUM_READERS-1:0]            rd_req,
  input  logic [NUM_READERS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READERS-1:0]            rd_gnt,
  output logic [NUM_READERS-1:0]            rd_valid,
  output logic [WORD_LENGTH-1:0]            rd_data,
  output logic [ADDR_WIDTH-1:0]             ram_address,
  output logic [WORD_LENGTH-1:0]            ram_data,
  output logic                              ram_wren,
  input  logic [WORD_LENGTH-1:0]            ram_q
);

  localparam int PW         = reader_id_width(NUM_READERS);
  localparam int BW         = $clog2(MAX_WR_BURST + 1);
  localparam int TAG_STAGES = MEM_BANK_RD_LATENCY - 1;

  logic [PW-1:0]          rr_ptr_reg, rr_ptr_next, arb_next_ptr;
  logic [BW-1:0]          burst_cnt_reg, burst_cnt_next;
  logic [NUM_READERS-1:0] arb_gnt;
  logic [NUM_READERS-1:0] tag_issue_reg;
  logic [NUM_READERS-1:0] tag_pipe_reg [TAG_STAGES];
  logic [ADDR_WIDTH-1:0]  rd_sel_addr;
  logic [ADDR_WIDTH-1:0]  ram_address_reg;
  logic [WORD_LENGTH-1:0] ram_data_reg;
  logic                   ram_wren_reg;
  logic [WORD_LENGTH-1:0] rd_data_reg;
  logic                   any_rd;
  logic                   wr_win;
  grant_kind_e            grant_kind;

  rr_arbiter #(.N(NUM_READERS)) u_rr_arbiter (
    .req      (rd_req),
    .ptr      (rr_ptr_reg),
    .gnt      (arb_gnt),
    .next_ptr (arb_next_ptr)
  );

  assign any_rd = |rd_req;
  assign wr_win = wr_req && (burst_cnt_reg < BW'(MAX_WR_BURST));
  // Grants are gated by reset_n directly so nothing is accepted while reset is asserted.
  assign wr_ack = reset_n && wr_win;
  assign rd_gnt = (reset_n && !wr_win) ? arb_gnt : '0;

  always_comb begin
    grant_kind = GRANT_NONE;
    if (wr_ack) begin
      grant_kind = GRANT_WR;
    end else if (|rd_gnt) begin
      grant_kind = GRANT_RD;
    end
  end

  always_comb begin
    rd_sel_addr = '0;
    for (int i = 0; i < NUM_READERS; i++) begin
      if (arb_gnt[i]) begin
        rd_sel_addr = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // The guard only counts writes that actually hold off a waiting reader.
  always_comb begin
    burst_cnt_next = burst_cnt_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (grant_kind == GRANT_RD) begin
      burst_cnt_next = '0;
      rr_ptr_next    = arb_next_ptr;
    end else if (!any_rd) begin
      burst_cnt_next = '0;
    end else if (grant_kind == GRANT_WR) begin
      burst_cnt_next = burst_cnt_reg + BW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_reg      <= '0;
      burst_cnt_reg   <= '0;
      tag_issue_reg   <= '0;
      ram_address_reg <= '0;
      ram_data_reg    <= '0;
      ram_wren_reg    <= 1'b0;
      rd_data_reg     <= '0;
      for (int i = 0; i < TAG_STAGES; i++) begin
        tag_pipe_reg[i] <= '0;
      end
    end else begin
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
      tag_issue_reg <= rd_gnt;
      rd_data_reg   <= ram_q;
      tag_pipe_reg[0] <= tag_issue_reg;
      for (int i = 1; i < TAG_STAGES; i++) begin
        tag_pipe_reg[i] <= tag_pipe_reg[i-1];
      end
      case (grant_kind)
        GRANT_WR: begin
          ram_address_reg <= wr_addr;
          ram_data_reg    <= wr_data;
          ram_wren_reg    <= 1'b1;
        end
        GRANT_RD: begin
          ram_address_reg <= rd_sel_addr;
          ram_wren_reg    <= 1'b0;
        end
        default: begin
          ram_wren_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ram_address = ram_address_reg;
  assign ram_data    = ram_data_reg;
  assign ram_wren    = ram_wren_reg;
  assign rd_valid    = tag_pipe_reg[TAG_STAGES-1];
  assign rd_data     = rd_data_reg;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Bench for mem_bank_ctrl: directed table, multi-cycle corner sequences, and a randomized run
// checked against a spec-level model with a behavioural bank attached.
module tb_mem_bank_ctrl;
  import mem_bank_pkg::*;

  localparam int WL = 24;
  localparam int AW = 13;
  localparam int NR = 4;
  localparam int MB = 8;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                wr_req;
  logic [AW-1:0]       wr_addr;
  logic [WL-1:0]       wr_data;
  logic                wr_ack;
  logic [NR-1:0]       rd_req;
  logic [NR*AW-1:0]    rd_addr;
  logic [NR-1:0]       rd_gnt;
  logic [NR-1:0]       rd_valid;
  logic [WL-1:0]       rd_data;
  logic [AW-1:0]       ram_address;
  logic [WL-1:0]       ram_data;
  logic                ram_wren;
  logic [WL-1:0]       ram_q;

  always #5 clock = ~clock;

  mem_bank_ctrl #(
    .WORD_LENGTH(WL), .ADDR_WIDTH(AW), .NUM_READERS(NR), .MAX_WR_BURST(MB)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q)
  );

  // Behavioural bank: registered address, registered output, write at the same edge.
  logic [WL-1:0] bank_mem [0:(1<<AW)-1];
  logic [AW-1:0] bank_addr_reg;
  always @(posedge clock) begin
    if (ram_wren) bank_mem[ram_address] <= ram_data;
    bank_addr_reg <= ram_address;
    ram_q         <= bank_mem[bank_addr_reg];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic          wr;
    logic [NR-1:0] rd;
    logic          exp_ack;
    logic [NR-1:0] exp_gnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic w, input logic [NR-1:0] r, input logic ea, input logic [NR-1:0] eg);
    vec_t v;
    v.wr = w; v.rd = r; v.exp_ack = ea; v.exp_gnt = eg;
    vecs.push_back(v);
  endtask

  task automatic set_rd_addr(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic drive_idle();
    wr_req = 1'b0;
    rd_req = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_address"}, 32'(ram_address), 32'd0);
    check({tag, "_ram_data"},    32'(ram_data),    32'd0);
    check({tag, "_ram_wren"},    32'(ram_wren),    32'd0);
    check({tag, "_rd_valid"},    32'(rd_valid),    32'd0);
    check({tag, "_rd_data"},     32'(rd_data),     32'd0);
    check({tag, "_wr_ack"},      32'(wr_ack),      32'd0);
    check({tag, "_rd_gnt"},      32'(rd_gnt),      32'd0);
  endtask

  // Entered just after the edge ending the grant cycle; watches up to 8 cycles.
  task automatic measure_return(output int lat, output logic [NR-1:0] v, output logic [WL-1:0] d);
    lat = -1; v = '0; d = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (lat < 0 && rd_valid != '0) begin
        lat = c; v = rd_valid; d = rd_data;
      end
    end
    step();
  endtask

  // Spec-level model state for the randomized run.
  typedef struct {
    int            due;
    int            rdr;
    logic [WL-1:0] data;
    bit            known;
  } ret_t;
  ret_t          pend[$];
  logic [WL-1:0] shadow [32];
  bit            known  [32];
  int            m_burst;
  int            m_ptr;
  int            cyc;

  initial begin
    int            lat;
    logic [NR-1:0] v;
    logic [WL-1:0] d;
    int            wr_pct, rd_pct;
    logic          exp_ack;
    logic [NR-1:0] exp_gnt;
    logic [NR-1:0] exp_v;
    ret_t          r;
    int            k;

    wr_addr = '0; wr_data = '0; rd_addr = '0;

    // Reset state, with requests held high to show grants are forced low.
    reset_n = 1'b0; wr_req = 1'b1; rd_req = '1;
    @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #1;
    drive_idle();
    reset_n = 1'b1;

    // Arbitration table from a fresh reset (burst_cnt=0, rr_ptr=0).
    for (int i = 0; i < 8; i++) add_vec(1'b1, 4'b1000, 1'b1, 4'b0000);
    add_vec(1'b1, 4'b1000, 1'b0, 4'b1000);
    for (int i = 0; i < 12; i++) add_vec(1'b1, 4'b0000, 1'b1, 4'b0000);
    add_vec(1'b0, 4'b1111, 1'b0, 4'b0001);
    add_vec(1'b0, 4'b1111, 1'b0, 4'b0010);
    add_vec(1'b0, 4'b1111, 1'b0, 4'b0100);
    add_vec(1'b0, 4'b1111, 1'b0, 4'b1000);
    for (int i = 0; i < 8; i++) add_vec(1'b1, 4'b1111, 1'b1, 4'b0000);
    add_vec(1'b1, 4'b1111, 1'b0, 4'b0001);
    add_vec(1'b1, 4'b1111, 1'b1, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      wr_req = vecs[i].wr;
      rd_req = vecs[i].rd;
      @(negedge clock);
      $display("table row %0d wr_req=%0b rd_req=%b -> wr_ack=%0b rd_gnt=%b", i, vecs[i].wr, vecs[i].rd, wr_ack, rd_gnt);
      check($sformatf("table%0d_wr_ack", i), 32'(wr_ack), 32'(vecs[i].exp_ack));
      check($sformatf("table%0d_rd_gnt", i), 32'(rd_gnt), 32'(vecs[i].exp_gnt));
      step();
    end
    drive_idle();
    repeat (6) step();

    // Isolated read of the top address.
    wr_req = 1'b1; wr_addr = 13'h1FFF; wr_data = 24'hABCDEF;
    @(negedge clock);
    check("iso_wr_ack", 32'(wr_ack), 32'd1);
    step();
    wr_req = 1'b0; rd_req = 4'b0010; set_rd_addr(1, 13'h1FFF);
    @(negedge clock);
    check("iso_rd_gnt", 32'(rd_gnt), 32'b0010);
    step();
    rd_req = '0;
    measure_return(lat, v, d);
    $display("isolated read lat=%0d rd_valid=%b rd_data=0x%06h", lat, v, d);
    check("iso_latency", 32'(lat), 32'd4);
    check("iso_rd_valid", 32'(v), 32'b0010);
    check("iso_rd_data", 32'(d), 32'hABCDEF);

    // Write immediately followed by a read of the same address.
    wr_req = 1'b1; wr_addr = 13'd5; wr_data = 24'h5A5A5A;
    step();
    wr_req = 1'b0;
    repeat (2) step();
    wr_req = 1'b1; wr_addr = 13'd5; wr_data = 24'h000111;
    @(negedge clock);
    check("haz_wr_ack", 32'(wr_ack), 32'd1);
    step();
    wr_req = 1'b0; rd_req = 4'b0001; set_rd_addr(0, 13'd5);
    @(negedge clock);
    check("haz_rd_gnt", 32'(rd_gnt), 32'b0001);
    step();
    rd_req = '0;
    measure_return(lat, v, d);
    $display("hazard read lat=%0d rd_valid=%b rd_data=0x%06h", lat, v, d);
    check("haz_latency", 32'(lat), 32'd4);
    check("haz_rd_valid", 32'(v), 32'b0001);
    check("haz_rd_data", 32'(d), 32'h000111);

    // Reset asserted mid-stream, then reader 2 granted on the first free cycle.
    wr_req = 1'b1; wr_addr = 13'd7; wr_data = 24'h123456; rd_req = '1;
    for (int i = 0; i < 4; i++) set_rd_addr(i, AW'(16 + i));
    repeat (5) step();
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clock);
    #1;
    drive_idle();
    rd_req = 4'b0100; set_rd_addr(2, 13'h0A5);
    reset_n = 1'b1;
    @(negedge clock);
    check("postreset_rd_gnt", 32'(rd_gnt), 32'b0100);
    check("postreset_wr_ack", 32'(wr_ack), 32'd0);
    step();
    rd_req = '0;
    measure_return(lat, v, d);
    $display("post-reset read lat=%0d rd_valid=%b", lat, v);
    check("postreset_latency", 32'(lat), 32'd4);
    check("postreset_rd_valid", 32'(v), 32'b0100);

    // Three reads in flight when reset hits: none may return, rr_ptr restarts at 0.
    for (int i = 0; i < 3; i++) begin
      rd_req = NR'(1 << i);
      @(negedge clock);
      check($sformatf("inflight_gnt%0d", i), 32'(rd_gnt), 32'(1 << i));
      step();
    end
    drive_idle();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      check($sformatf("flushed_rd_valid_c%0d", c), 32'(rd_valid), 32'd0);
    end
    step();
    rd_req = '1;
    @(negedge clock);
    $display("rr restart rd_gnt=%b", rd_gnt);
    check("rr_restart_gnt", 32'(rd_gnt), 32'b0001);
    step();
    drive_idle();

    // Randomized run against the spec-level model.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    m_burst = 0; m_ptr = 0; cyc = 0;
    for (int i = 0; i < 32; i++) begin
      known[i] = 1'b0; shadow[i] = '0;
    end
    for (int p = 0; p < 4; p++) begin
      case (p)
        0: begin wr_pct = 30;  rd_pct = 30; end
        1: begin wr_pct = 90;  rd_pct = 90; end
        2: begin wr_pct = 100; rd_pct = 100; end
        default: begin wr_pct = 10; rd_pct = 80; end
      endcase
      for (int n = 0; n < 500; n++) begin
        @(negedge clock);
        cyc++;
        exp_ack = wr_req && (m_burst < MB);
        exp_gnt = '0;
        k = -1;
        if (!exp_ack) begin
          for (int j = 0; j < NR; j++) begin
            if (k < 0 && rd_req[(m_ptr + j) % NR]) k = (m_ptr + j) % NR;
          end
          if (k >= 0) exp_gnt[k] = 1'b1;
        end
        exp_v = '0;
        r.known = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          r = pend.pop_front();
          exp_v[r.rdr] = 1'b1;
        end
        check("rand_wr_ack", 32'(wr_ack), 32'(exp_ack));
        check("rand_rd_gnt", 32'(rd_gnt), 32'(exp_gnt));
        check("rand_rd_valid", 32'(rd_valid), 32'(exp_v));
        if (exp_v != '0 && r.known) check("rand_rd_data", 32'(rd_data), 32'(r.data));

        if (exp_ack) begin
          shadow[wr_addr[4:0]] = wr_data;
          known[wr_addr[4:0]]  = 1'b1;
        end
        if (k >= 0) begin
          r.due   = cyc + MEM_BANK_RD_LATENCY;
          r.rdr   = k;
          r.data  = shadow[rd_addr[k*AW +: 5]];
          r.known = known[rd_addr[k*AW +: 5]];
          pend.push_back(r);
          m_ptr   = (k + 1) % NR;
          m_burst = 0;
        end else if (rd_req == '0) begin
          m_burst = 0;
        end else if (exp_ack) begin
          m_burst = m_burst + 1;
        end

        step();
        if (exp_ack) wr_req = 1'b0;
        for (int i = 0; i < NR; i++) if (exp_gnt[i]) rd_req[i] = 1'b0;
        if (!wr_req && $urandom_range(0, 99) < wr_pct) begin
          wr_req  = 1'b1;
          wr_addr = AW'($urandom_range(0, 31));
          wr_data = WL'($urandom);
        end
        for (int i = 0; i < NR; i++) begin
          if (!rd_req[i] && $urandom_range(0, 99) < rd_pct) begin
            rd_req[i] = 1'b1;
            set_rd_addr(i, AW'($urandom_range(0, 31)));
          end
        end
      end
      $display("random phase %0d done wr_pct=%0d rd_pct=%0d checks=%0d", p, wr_pct, rd_pct, checks);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
